// File: rtl/display_pkg.sv
// display_pkg: shared constants and helpers for the 7-segment display blocks
package display_pkg;

    // Wide enough for the largest supported display; callers slice to their width.
    localparam logic [7:0] ANODE_OFF = 8'hFF;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [3:0] nibble_sel(input logic [31:0] v, input logic [2:0] i);
        return v[{i, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/divisor_tick.sv
// divisor_tick: free-running prescaler counting 0..DIV-1 with a wrap tick
module divisor_tick #(
    parameter int DIV = 50000,
    parameter int W   = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic [W-1:0] cnt,
    output logic         tick
);

    assign tick = cnt == W'(DIV - 1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else        cnt <= tick ? '0 : cnt + 1'b1;

endmodule

// File: rtl/barrido_display.sv
// barrido_display: time-multiplexed scanner for a common-anode 7-segment display
// with frame-aligned value updates and per-digit blanking
module barrido_display
    import display_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] value_in,
    input  logic                  load,
    input  logic [N_DIGITS-1:0]   blank_mask,
    output logic [3:0]            bin,
    output logic [N_DIGITS-1:0]   anodo,
    output logic                  pending,
    output logic                  frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = idx_width(N_DIGITS);
    localparam int VW = 4 * N_DIGITS;

    logic [CW-1:0] cnt;
    logic          tick;
    logic [IW-1:0] idx;
    logic [VW-1:0] staging, active;
    logic          boundary;

    divisor_tick #(.DIV(REFRESH_DIV), .W(CW)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .cnt   (cnt),
        .tick  (tick)
    );

    assign boundary = tick && idx == IW'(N_DIGITS - 1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            idx        <= '0;
            staging    <= '0;
            active     <= '0;
            pending    <= 1'b0;
            bin        <= 4'h0;
            anodo      <= ANODE_OFF[N_DIGITS-1:0];
            frame_done <= 1'b0;
        end else begin
            idx        <= tick ? (idx == IW'(N_DIGITS - 1) ? '0 : idx + 1'b1) : idx;
            staging    <= load ? value_in : staging;
            // a load landing on the boundary bypasses staging so the newest value wins
            active     <= boundary ? (load ? value_in : pending ? staging : active) : active;
            pending    <= !boundary && (load || pending);
            bin        <= nibble_sel(32'(active), 3'(idx));
            anodo      <= (cnt < CW'(GUARD) || blank_mask[idx]) ? ANODE_OFF[N_DIGITS-1:0]
                                                                : ~(N_DIGITS'(1) << idx);
            frame_done <= boundary;
        end

endmodule
